// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for the bit-serial adder.
// The producer/consumer side takes the master modport; the adder takes the slave modport.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Overflow;

  modport master (
    output in_valid, A, B, Cin, out_ready,
    input  in_ready, out_valid, Sum, Cout, Overflow
  );

  modport slave (
    input  in_valid, A, B, Cin, out_ready,
    output in_ready, out_valid, Sum, Cout, Overflow
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell and a registered carry are reused
// LSB-first over WIDTH clocks. Operands and results move on valid/ready handshakes.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, sum_sr_reg;
  logic             carry_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg, ovf_reg;

  logic bit_s, carry_next;

  always_comb begin
    state_next = state_reg;
    bit_s      = a_reg[0] ^ b_reg[0] ^ carry_reg;
    carry_next = (a_reg[0] & b_reg[0]) | (a_reg[0] & carry_reg) | (b_reg[0] & carry_reg);
    case (state_reg)
      IDLE:    if (bus.in_valid)     state_next = RUN;
      RUN:     if (cnt_reg == LAST)  state_next = DONE;
      DONE:    if (bus.out_ready)    state_next = IDLE;
      default:                       state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      sum_sr_reg <= '0;
      carry_reg  <= 1'b0;
      cnt_reg    <= '0;
      sum_reg    <= '0;
      cout_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg     <= bus.A;
            b_reg     <= bus.B;
            carry_reg <= bus.Cin;
            cnt_reg   <= '0;
          end
        end
        RUN: begin
          a_reg      <= a_reg >> 1;
          b_reg      <= b_reg >> 1;
          sum_sr_reg <= {bit_s, sum_sr_reg[WIDTH-1:1]};
          carry_reg  <= carry_next;
          if (cnt_reg == LAST) begin
            // carry_reg here is the carry into the MSB, carry_next the carry out of it
            sum_reg  <= {bit_s, sum_sr_reg[WIDTH-1:1]};
            cout_reg <= carry_next;
            ovf_reg  <= carry_reg ^ carry_next;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.Sum       = sum_reg;
  assign bus.Cout      = cout_reg;
  assign bus.Overflow  = ovf_reg;
endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of the bit-serial adder: latency, results, flags,
// backpressure and asynchronous reset in the middle of an operation.
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  serial_adder_if #(.WIDTH(8)) bus ();

  serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Drives one operation and returns the result seen while out_valid is high.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input int stall, input bit handshake,
                        output logic [7:0] s, output logic co, output logic ov,
                        output int lat);
    int guard;
    @(negedge clk);
    bus.A = a; bus.B = b; bus.Cin = cin; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
    end
    if (!bus.out_valid) lat = -1;
    repeat (stall) @(negedge clk);
    @(negedge clk);
    s = bus.Sum; co = bus.Cout; ov = bus.Overflow;
    if (handshake) begin
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [11:0] got;
    #1;
    got = {bus.in_ready, bus.out_valid, bus.Sum, bus.Cout, bus.Overflow};
    n_tests++;
    if (got !== 12'b1_0_00000000_0_0) begin
      n_fail++;
      $display("FAIL reset_state got=%b required=%b", got, 12'b1_0_00000000_0_0);
    end
    $display("[TB] reset: in_ready=%b out_valid=%b Sum=%h", bus.in_ready, bus.out_valid, bus.Sum);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] s; logic co, ov; int lat;
    run_op(8'h3C, 8'h15, 1'b0, 0, 1'b1, s, co, ov, lat);
    $display("[TB] op A=3c B=15 Cin=0 -> Sum=%h Cout=%b Ovf=%b lat=%0d", s, co, ov, lat);
    n_tests++;
    if (lat !== 8) begin n_fail++; $display("FAIL basic_latency got=%0d required=8", lat); end
    n_tests++;
    if ({co, ov, s} !== {1'b0, 1'b0, 8'h51}) begin
      n_fail++; $display("FAIL basic_result got=%b/%b/%h required=0/0/51", co, ov, s);
    end
    n_tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_after_handshake in_ready=%b out_valid=%b required 1/0",
               bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_carry_flags();
    logic [7:0] va [4] = '{8'hFF, 8'h7F, 8'h80, 8'h00};
    logic [7:0] vb [4] = '{8'h01, 8'h01, 8'h80, 8'h00};
    logic       vc [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] es [4] = '{8'h00, 8'h80, 8'h01, 8'h01};
    logic       eco[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic       eov[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [7:0] s; logic co, ov; int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], vc[i], i, 1'b1, s, co, ov, lat);
      $display("[TB] op A=%h B=%h Cin=%b -> Sum=%h Cout=%b Ovf=%b lat=%0d",
               va[i], vb[i], vc[i], s, co, ov, lat);
      n_tests++;
      if ({co, ov, s} !== {eco[i], eov[i], es[i]} || lat !== 8) begin
        n_fail++;
        $display("FAIL carry_case%0d got=%b/%b/%h lat=%0d required=%b/%b/%h lat=8",
                 i, co, ov, s, lat, eco[i], eov[i], es[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] s; logic co, ov; int lat;
    run_op(8'h3C, 8'h15, 1'b0, 0, 1'b0, s, co, ov, lat);
    for (int i = 0; i < 5; i++) begin
      bus.A = 8'hAA; bus.B = 8'h11; bus.in_valid = ~bus.in_valid;
      @(negedge clk);
      $display("[TB] stall %0d: in_valid=%b Sum=%h in_ready=%b out_valid=%b",
               i, bus.in_valid, bus.Sum, bus.in_ready, bus.out_valid);
      n_tests++;
      if (bus.Sum !== 8'h51 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL backpressure_hold%0d Sum=%h in_ready=%b out_valid=%b required 51/0/1",
                 i, bus.Sum, bus.in_ready, bus.out_valid);
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.Sum !== 8'h51) begin
      n_fail++;
      $display("FAIL backpressure_release out_valid=%b in_ready=%b Sum=%h required 0/1/51",
               bus.out_valid, bus.in_ready, bus.Sum);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_idle in_ready=%b out_valid=%b required 1/0",
               bus.in_ready, bus.out_valid);
    end
    $display("[TB] backpressure released, in_ready=%b", bus.in_ready);
  endtask

  task automatic test_reset_mid_op();
    logic [10:0] got;
    bit seen_valid = 1'b0;
    bit lost_ready = 1'b0;
    @(negedge clk);
    bus.A = 8'h12; bus.B = 8'h34; bus.Cin = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    got = {bus.out_valid, bus.Sum, bus.Cout, bus.Overflow};
    n_tests++;
    if (got !== 11'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_op got=%b in_ready=%b required=%b in_ready=1", got, bus.in_ready, 11'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen_valid = 1'b1;
      if (!bus.in_ready) lost_ready = 1'b1;
    end
    n_tests++;
    if (seen_valid || lost_ready) begin
      n_fail++;
      $display("FAIL reset_stale stale_out_valid=%b in_ready_dropped=%b required 0/0",
               seen_valid, lost_ready);
    end
    $display("[TB] reset mid-op: Sum=%h out_valid=%b in_ready=%b", bus.Sum, bus.out_valid, bus.in_ready);
  endtask

  task automatic test_random();
    logic [7:0] a, b, s; logic cin, co, ov, exp_ov; int lat;
    logic [8:0] exp_full;
    int sres;
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      run_op(a, b, cin, $urandom_range(0, 3), 1'b1, s, co, ov, lat);
      exp_full = {1'b0, a} + {1'b0, b} + {8'b0, cin};
      sres = int'($signed(a)) + int'($signed(b)) + int'(cin);
      exp_ov = (sres > 127) || (sres < -128);
      $display("[TB] rnd %0d A=%h B=%h Cin=%b -> Sum=%h Cout=%b Ovf=%b", i, a, b, cin, s, co, ov);
      n_tests++;
      if ({co, s} !== exp_full || ov !== exp_ov || lat !== 8) begin
        n_fail++;
        $display("FAIL random%0d got=%b/%h ovf=%b lat=%0d required=%h ovf=%b lat=8",
                 i, co, s, ov, lat, exp_full, exp_ov);
      end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.Cin = 1'b0; bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_carry_flags();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
